// File: rtl/pipe_scaler_pkg.sv
// rtl/pipe_scaler_pkg.sv - default sizes and per-sample scale helpers for pipe_scaler
// Optional macro PIPE_SCALER_SAT_EN selects saturation instead of truncation on overflow.
package pipe_scaler_pkg;

   localparam int DEF_NUM_CH = 2;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_CF_W   = 4;
   localparam int DEF_DEPTH  = 2;

   // Helpers work on a wide word so they serve any DATA_W/CF_W with DATA_W+CF_W <= MAX_W.
   localparam int MAX_W = 64;
   typedef logic [MAX_W-1:0] word_t;

   function automatic word_t width_mask(input int w);
      word_t m;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic is_sentinel(input word_t s, input int w);
      word_t m;
      m = width_mask(w);
      return ((s & m) == '0) || ((s & m) == m);
   endfunction

   function automatic word_t scale_sample(input word_t s, input word_t cf, input int dw, input int cw);
      word_t m;
      word_t p;
      m = width_mask(dw);
      if (is_sentinel(s, dw)) return s & m;
      p = (s & m) * (cf & width_mask(cw));
`ifdef PIPE_SCALER_SAT_EN
      // Saturate one below all-ones so an overflow never reads back as a sentinel.
      if ((p >> dw) != '0) return m - word_t'(1);
`endif
      return p & m;
   endfunction

endpackage

// File: rtl/pipe_scaler_stage.sv
// rtl/pipe_scaler_stage.sv - one elastic valid/ready register stage
module pipe_scaler_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         up_ready,
   output logic         dn_valid,
   output logic [W-1:0] dn_data,
   input  logic         dn_ready
);

   assign up_ready = !dn_valid || dn_ready;

   // Data only loads with a valid beat; an empty stage keeps stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         if (up_valid) dn_data <= up_data;
      end
   end

endmodule

// File: rtl/pipe_scaler.sv
// rtl/pipe_scaler.sv - multi-channel coefficient scale pipeline with valid/ready handshake
// Optional macro PIPE_SCALER_SAT_EN (handled in pipe_scaler_pkg) enables overflow saturation.
module pipe_scaler
   import pipe_scaler_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CF_W   = DEF_CF_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [CF_W-1:0]          i_cf,
   input  logic [NUM_CH*DATA_W-1:0] i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [NUM_CH*DATA_W-1:0] o_data
);

   localparam int W = NUM_CH * DATA_W;

   logic [DEPTH:0]        v;
   logic [DEPTH:0]        rdy;
   logic [DEPTH:0][W-1:0] d;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      word_t sc;
      logic  unused_bits;
      assign sc = scale_sample(word_t'(i_data[k*DATA_W +: DATA_W]), word_t'(i_cf), DATA_W, CF_W);
      assign d[0][k*DATA_W +: DATA_W] = sc[DATA_W-1:0];
      assign unused_bits = ^sc[MAX_W-1:DATA_W];
   end

   assign v[0]       = i_valid;
   assign rdy[DEPTH] = i_ready;
   assign o_ready    = rdy[0];
   assign o_valid    = v[DEPTH];
   assign o_data     = d[DEPTH];

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      pipe_scaler_stage #(.W(W)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .up_valid (v[s]),
         .up_data  (d[s]),
         .up_ready (rdy[s]),
         .dn_valid (v[s+1]),
         .dn_data  (d[s+1]),
         .dn_ready (rdy[s+1])
      );
   end

endmodule

// File: tb/tb_pipe_scaler.sv
// tb/tb_pipe_scaler.sv - scoreboard testbench for pipe_scaler
module tb_pipe_scaler;

   localparam int NUM_CH = 2;
   localparam int DATA_W = 16;
   localparam int CF_W   = 4;
   localparam int DEPTH  = 2;
   localparam int W      = NUM_CH * DATA_W;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_valid;
   logic            o_ready;
   logic [CF_W-1:0] i_cf;
   logic [W-1:0]    i_data;
   logic            o_valid;
   logic            i_ready;
   logic [W-1:0]    o_data;

   int checks    = 0;
   int failures  = 0;
   int out_cnt   = 0;
   int acc_cnt   = 0;
   int stall_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] prev_data;
   logic         prev_stall = 1'b0;

`ifdef PIPE_SCALER_SAT_EN
   localparam logic [15:0] OV_EXP = 16'hFFFE;
`else
   localparam logic [15:0] OV_EXP = 16'h0002;
`endif

   always #5 clk = ~clk;

   pipe_scaler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CF_W(CF_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_cf    (i_cf),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data)
   );

   function automatic logic [15:0] model(input logic [15:0] s, input logic [3:0] cf);
      logic [19:0] p;
      if (s == 16'h0000 || s == 16'hFFFF) return s;
      p = {4'b0, s} * {16'b0, cf};
`ifdef PIPE_SCALER_SAT_EN
      if (p[19:16] != 4'b0) return 16'hFFFE;
`endif
      return p[15:0];
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: i_ready only changes 1ns after a rising edge, so at the falling edge it is
   // final for the upcoming transfer edge.
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         if (!i_ready) begin
            if (prev_stall) check("stall_stable", o_data, prev_data);
            prev_stall = 1'b1;
            prev_data  = o_data;
         end else begin
            prev_stall = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out actual=%h required=none", o_data);
            end else begin
               check("out_data", o_data, exp_q.pop_front());
            end
            out_cnt++;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Called 1ns after an edge; returns 1ns after the edge that accepted the beat, i_valid left high.
   task automatic send(input logic [W-1:0] data, input logic [CF_W-1:0] cf, input logic [W-1:0] exp);
      int n;
      n = 0;
      i_valid = 1'b1;
      i_data  = data;
      i_cf    = cf;
      #1;
      while (!o_ready && n < 200) begin
         stall_cnt++;
         n++;
         @(posedge clk);
         #2;
      end
      if (!o_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=o_ready_low required=accept");
      end else begin
         exp_q.push_back(exp);
         acc_cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
   endtask

   initial begin
      int base;
      logic [15:0] s0, s1;
      logic [3:0]  cf;

      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_data = '0;
      i_cf = '0;
      #1;
      check("reset_o_valid", W'(o_valid), '0);
      check("reset_o_data", o_data, '0);
      check("reset_o_ready", W'(o_ready), W'(1));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic scale with latency check
      send({16'h0010, 16'h0003}, 4'd2, {16'h0020, 16'h0006});
      i_valid = 1'b0;
      check("latency_early", W'(o_valid), '0);
      repeat (DEPTH - 1) begin
         @(posedge clk);
         #1;
      end
      check("latency_valid", W'(o_valid), W'(1));
      drain();

      // Sentinels, zero coefficient, overflow
      send({16'hFFFF, 16'h0000}, 4'd3, {16'hFFFF, 16'h0000});
      send({16'h0000, 16'h1234}, 4'd0, {16'h0000, 16'h0000});
      send({16'h0001, 16'h8001}, 4'd2, {16'h0002, OV_EXP});
      i_valid = 1'b0;
      drain();

      // Backpressure: sink stalled while five beats are offered
      i_ready = 1'b0;
      acc_cnt = 0;
      base = out_cnt;
      fork
         begin
            for (int i = 1; i <= 5; i++) send({16'h0000, 16'(i)}, 4'd1, {16'h0000, 16'(i)});
            i_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            check("bp_accepted", W'(acc_cnt), W'(2));
            check("bp_o_ready", W'(o_ready), '0);
            i_ready = 1'b1;
         end
      join
      drain();
      check("bp_out_count", W'(out_cnt - base), W'(5));

      // Full throughput against the reference model
      stall_cnt = 0;
      base = out_cnt;
      for (int i = 0; i < 100; i++) begin
         s0 = 16'(i * 613 + 7);
         s1 = 16'(i * 4099) ^ 16'hA5A5;
         if (i % 25 == 0) s0 = 16'hFFFF;
         if (i % 33 == 1) s1 = 16'h0000;
         cf = 4'(i % 16);
         send({s1, s0}, cf, {model(s1, cf), model(s0, cf)});
      end
      i_valid = 1'b0;
      drain();
      check("thru_stalls", W'(stall_cnt), '0);
      check("thru_out_count", W'(out_cnt - base), W'(100));

      // Reset with two beats in flight
      i_ready = 1'b0;
      send({16'h1111, 16'h0101}, 4'd1, {16'h1111, 16'h0101});
      send({16'h2222, 16'h0202}, 4'd1, {16'h2222, 16'h0202});
      i_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_o_valid", W'(o_valid), '0);
      check("midrst_o_data", o_data, '0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      i_ready = 1'b1;
      base = out_cnt;
      send({16'h0002, 16'h0005}, 4'd3, {16'h0006, 16'h000F});
      i_valid = 1'b0;
      repeat (DEPTH - 1) begin
         @(posedge clk);
         #1;
      end
      check("postrst_valid", W'(o_valid), W'(1));
      check("postrst_data", o_data, {16'h0006, 16'h000F});
      repeat (6) @(posedge clk);
      #1;
      check("postrst_out_count", W'(out_cnt - base), W'(1));
      check("final_queue_empty", W'(exp_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_scaler.md
Name: pipe_scaler

Overview:
- Multi-channel, parametrised scale pipeline: multiplies each channel sample by a shared coefficient and returns the scaled samples.
- Sentinel samples (all-zeros, all-ones) pass through unmodified.
- Valid/ready handshaked elastic pipeline of configurable depth, so it can sit between a streaming source and a backpressuring sink in the datapath.
- Generalises the fixed 2-channel, 16-bit, always-ready scale pipe.

Parameters:
- NUM_CH, 2, number of data channels (>=1).
- DATA_W, 16, bits per channel sample (>=2).
- CF_W, 4, coefficient width, unsigned.
- DEPTH, 2, register stages from input to output (>=1); equals latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept an input beat this cycle.
- i_cf  input  CF_W  unsigned coefficient, sampled with the beat.
- i_data  input  NUM_CH*DATA_W  packed samples; channel k at bits [k*DATA_W +: DATA_W].
- o_valid  output  1  output beat valid.
- i_ready  input  1  sink accepts the output beat.
- o_data  output  NUM_CH*DATA_W  packed scaled samples, same packing as i_data.

Behaviour:
- Reset: clk single clock; rst asynchronous active-high. While rst=1, all stage valids, o_valid and o_data are 0 immediately, without waiting for a clock edge.
- o_ready is combinational from pipeline state and i_ready; it is 0 only when every stage is full and i_ready=0.
- Input accepted on a rising edge with i_valid && o_ready. Output transferred on a rising edge with o_valid && i_ready.
- Stage k holds valid v[k] and data. Stage k advances when !v[k] || ready[k+1]; the last stage uses i_ready. Ready propagates combinationally back through the chain; no bubbles under continuous flow.
- Latency: beat accepted at edge N appears on o_valid/o_data after edge N+DEPTH-1, when there is no backpressure. Throughput is 1 beat/cycle.
- Order is preserved. No beat is dropped or duplicated. o_data stays stable while o_valid && !i_ready.
- Per channel, computed in stage 0:
  - s == 0 or s == all-ones -> result = s.
  - otherwise p = s * i_cf, full width DATA_W+CF_W; result = p[DATA_W-1:0] (truncate).
- i_cf == 0 with a non-sentinel sample -> result 0.
- Channels are independent; one shared i_cf per beat.
- Data registers of empty stages keep stale values; only valid qualifies data.
- Simultaneous accept and emit on a full pipeline (i_ready=1) is legal; occupancy is unchanged.
- rst asserted mid-stream: all in-flight beats are discarded. After deassertion the first accepted beat emerges DEPTH cycles later.

Optional Feature:
- Macro PIPE_SCALER_SAT_EN.
- Defined: if p[DATA_W+CF_W-1:DATA_W] != 0, result = all-ones minus 1 (e.g. 16'hFFFE). This saturates without producing the all-ones sentinel.
- Not defined: plain truncation as above.
- Sentinel pass-through is identical in both builds.

Decomposition:
- Package pipe_scaler_pkg:
  - default constants for NUM_CH, DATA_W, CF_W, DEPTH;
  - function is_sentinel(sample);
  - function scale_sample(sample, cf), with the truncate/saturate selection under the macro.
- Sub-module pipe_scaler_stage: one elastic register stage (valid, data, ready-in/ready-out) of width NUM_CH*DATA_W. Instantiated DEPTH times via generate; stage 0's data input is the scaled vector.

Test Plan:
- Basic scale (defaults, i_ready=1): beat ch0=16'h0003, ch1=16'h0010, cf=2 -> exactly 2 cycles later o_valid=1, o_data ch0=16'h0006, ch1=16'h0020.
- Sentinel pass-through: ch0=16'h0000, ch1=16'hFFFF, cf=3 -> outputs 16'h0000, 16'hFFFF. Also ch0=16'h1234, cf=0 -> 16'h0000.
- Overflow: ch0=16'h8001, cf=2 -> 16'h0002 without the macro; 16'hFFFE with PIPE_SCALER_SAT_EN.
- Backpressure: hold i_ready=0 and stream beats 1..5 (ch0=1..5, cf=1) -> o_ready falls after 2 accepted beats. Then release i_ready -> outputs 1..5 in order, each exactly once, o_data stable while stalled.
- Full throughput: continuous 100 beats with i_ready=1 -> o_ready never 0, one output per cycle, matching a reference model.
- Reset mid-stream: assert rst between edges with 2 beats in flight -> o_valid and o_data drop to 0 before the next edge. After release a new beat emerges after DEPTH cycles, with no residue from the discarded beats.
